// File: rtl/as65_pin_cond.sv
// Input-pad conditioner for the 65RV32 core: sync, optional glitch filter (AS65_GLITCH_FILTER_EN), NMI latch, SO pulse, reset stretch.
// Latency: SYNC_STAGES (+FILT_LEN when filtered) edges to the filtered level, outputs one edge later.
// Backpressure: none; pads are free-running levels and nmi_ack is a single-cycle strobe.
module as65_pin_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int RST_STRETCH = 8
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic res_pad_n,
    input  logic irq_pad_n,
    input  logic nmi_pad_n,
    input  logic rdy_pad,
    input  logic so_pad_n,
    input  logic nmi_ack,
    output logic cpu_rst_n,
    output logic irq_n,
    output logic nmi_n,
    output logic rdy,
    output logic so_n
);

    localparam int P_RES = 0;
    localparam int P_IRQ = 1;
    localparam int P_NMI = 2;
    localparam int P_RDY = 3;
    localparam int P_SO  = 4;
    // RESn resets asserted so the core always sees a full stretch after power-on.
    localparam logic [4:0] PAD_RST  = 5'b11110;
    localparam logic [7:0] RST_LOAD = 8'(RST_STRETCH - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("as65_pin_cond: SYNC_STAGES out of range 2..4");
    end
    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt
        $error("as65_pin_cond: FILT_LEN out of range 1..15");
    end
    if (RST_STRETCH < 1 || RST_STRETCH > 255) begin : g_bad_stretch
        $error("as65_pin_cond: RST_STRETCH out of range 1..255");
    end

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } state_t;

    logic [4:0] pads;
    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] sync_out;
    logic [4:0] filt;

    assign pads     = {so_pad_n, rdy_pad, nmi_pad_n, irq_pad_n, res_pad_n};
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= PAD_RST;
            end
        end else begin
            sync_q[0] <= pads;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef AS65_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN);

    logic [CW-1:0] fcnt_q [5];
    logic [4:0]    filt_q;

    // Counts consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= PAD_RST;
            for (int i = 0; i < 5; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync_out[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == CNT_MAX - CW'(1)) begin
                    filt_q[i] <= sync_out[i];
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] != CNT_MAX) begin
                    fcnt_q[i] <= fcnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_out;
`endif

    state_t     state_q, state_d;
    logic [7:0] scnt_q, scnt_d;
    logic       run;

    // The exit test looks one count ahead so cpu_rst_n rises exactly RST_STRETCH edges after filtered RES.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        if (!filt[P_RES]) begin
            state_d = HOLD;
        end else begin
            case (state_q)
                HOLD: begin
                    if (RST_STRETCH == 1) begin
                        state_d = RUN;
                    end else begin
                        state_d = STRETCH;
                        scnt_d  = RST_LOAD;
                    end
                end
                STRETCH: begin
                    if (scnt_q <= 8'd1) begin
                        scnt_d  = 8'd0;
                        state_d = RUN;
                    end else begin
                        scnt_d = scnt_q - 8'd1;
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = HOLD;
            endcase
        end
    end

    assign run = (state_q == RUN);

    logic nmi_prev_q, so_prev_q;
    logic nmi_pend_q, irq_q, rdy_q, so_q;
    logic nmi_fall, so_fall;

    assign nmi_fall = nmi_prev_q & ~filt[P_NMI];
    assign so_fall  = so_prev_q & ~filt[P_SO];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HOLD;
            scnt_q     <= 8'd0;
            nmi_prev_q <= 1'b1;
            so_prev_q  <= 1'b1;
            nmi_pend_q <= 1'b0;
            irq_q      <= 1'b1;
            rdy_q      <= 1'b1;
            so_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            nmi_prev_q <= filt[P_NMI];
            so_prev_q  <= filt[P_SO];
            irq_q      <= run ? filt[P_IRQ] : 1'b1;
            rdy_q      <= run ? filt[P_RDY] : 1'b1;
            so_q       <= ~(run & so_fall);
            // A new edge beats a simultaneous acknowledge so no request is lost.
            if (!run) begin
                nmi_pend_q <= 1'b0;
            end else if (nmi_fall) begin
                nmi_pend_q <= 1'b1;
            end else if (nmi_ack) begin
                nmi_pend_q <= 1'b0;
            end
        end
    end

    assign cpu_rst_n = run;
    assign irq_n     = irq_q;
    assign rdy       = rdy_q;
    assign so_n      = so_q;
    assign nmi_n     = ~nmi_pend_q;

endmodule

// File: tb/tb_as65_pin_cond.sv
// Bench for as65_pin_cond: directed steps plus random pads against a sample-history reference model.
module tb_as65_pin_cond;

    localparam int SYNC = 2;
    localparam int FILT = 3;
    localparam int RSTS = 8;
    localparam int MAXE = 4000;
`ifdef AS65_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
    localparam int LAT_OUT = 6;
    localparam int LAT_RST = 13;
`else
    localparam bit FILT_ON = 1'b0;
    localparam int LAT_OUT = 3;
    localparam int LAT_RST = 10;
`endif
    // Bit order of the history vectors: res, irq, nmi, rdy, so.
    localparam logic [4:0] RV = 5'b11110;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    logic res_pad_n = 1'b1, irq_pad_n = 1'b1, nmi_pad_n = 1'b1, rdy_pad = 1'b1, so_pad_n = 1'b1;
    logic nmi_ack = 1'b0;
    logic cpu_rst_n, irq_n, nmi_n, rdy, so_n;

    as65_pin_cond #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .RST_STRETCH(RSTS)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .res_pad_n(res_pad_n), .irq_pad_n(irq_pad_n), .nmi_pad_n(nmi_pad_n),
        .rdy_pad(rdy_pad), .so_pad_n(so_pad_n), .nmi_ack(nmi_ack),
        .cpu_rst_n(cpu_rst_n), .irq_n(irq_n), .nmi_n(nmi_n), .rdy(rdy), .so_n(so_n)
    );

    always #5 clk_i = ~clk_i;

    logic [4:0] padh [0:MAXE];
    logic [4:0] fh   [0:MAXE];
    bit         runh [0:MAXE];
    bit         pend;
    int         e;
    int         checks;
    int         errors;

    function automatic logic syncv(int p, int k);
        int s;
        s = k - SYNC + 1;
        if (s >= 1) return padh[s][p];
        return RV[p];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b at edge %0d", tag, obs, exp, e);
        end
    endtask

    // One rising edge: record the applied pads, advance the model, then compare every output.
    task automatic step();
        logic prevrun, so_fall, nmi_fall, flip, s;
        @(posedge clk_i);
        e++;
        if (e >= MAXE) begin
            $display("FAIL model_overflow edge %0d limit %0d", e, MAXE);
            $fatal(1, "history overflow");
        end
        padh[e] = {so_pad_n, rdy_pad, nmi_pad_n, irq_pad_n, res_pad_n};
        for (int p = 0; p < 5; p++) begin
            if (FILT_ON) begin
                // Level flips once the last FILT synchronized samples all disagree with it.
                fh[e][p] = fh[e-1][p];
                flip = 1'b1;
                for (int j = 1; j <= FILT; j++) begin
                    s = (e - j >= 0) ? syncv(p, e - j) : RV[p];
                    if (s == fh[e-1][p]) flip = 1'b0;
                end
                if (flip) fh[e][p] = ~fh[e-1][p];
            end else begin
                fh[e][p] = syncv(p, e);
            end
        end
        runh[e] = 1'b1;
        for (int j = 1; j <= RSTS; j++) begin
            if (e - j < 0) runh[e] = 1'b0;
            else if (!fh[e-j][0]) runh[e] = 1'b0;
        end
        prevrun  = runh[e-1];
        so_fall  = (e >= 2) && fh[e-2][4] && !fh[e-1][4];
        nmi_fall = (e >= 2) && fh[e-2][2] && !fh[e-1][2];
        if (!prevrun) pend = 1'b0;
        else if (nmi_fall) pend = 1'b1;
        else if (nmi_ack) pend = 1'b0;
        #1;
        chk("model_cpu_rst_n", cpu_rst_n, runh[e]);
        chk("model_irq_n", irq_n, prevrun ? fh[e-1][1] : 1'b1);
        chk("model_rdy", rdy, prevrun ? fh[e-1][3] : 1'b1);
        chk("model_so_n", so_n, ~(prevrun & so_fall));
        chk("model_nmi_n", nmi_n, ~pend);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        e = 0;
        pend = 1'b0;
        padh[0] = 5'b11111;
        fh[0] = RV;
        runh[0] = 1'b0;

        // Power-on: outputs at reset values while rst_n is low.
        #12;
        chk("reset_cpu_rst_n", cpu_rst_n, 1'b0);
        chk("reset_irq_n", irq_n, 1'b1);
        chk("reset_nmi_n", nmi_n, 1'b1);
        chk("reset_rdy", rdy, 1'b1);
        chk("reset_so_n", so_n, 1'b1);
        rst_n = 1'b1;
        for (int i = 1; i <= LAT_RST + 2; i++) begin
            step();
            chk("por_release", cpu_rst_n, (i >= LAT_RST) ? 1'b1 : 1'b0);
        end
        repeat (4) step();

        // IRQ glitch of 2 cycles, then a 4-cycle pulse.
        for (int i = 1; i <= 12; i++) begin
            irq_pad_n = (i <= 2) ? 1'b0 : 1'b1;
            step();
            chk("irq_glitch2", irq_n, (!FILT_ON && (i == LAT_OUT || i == LAT_OUT + 1)) ? 1'b0 : 1'b1);
        end
        for (int i = 1; i <= 16; i++) begin
            irq_pad_n = (i <= 4) ? 1'b0 : 1'b1;
            step();
            chk("irq_pulse4", irq_n, (i >= LAT_OUT && i <= LAT_OUT + 3) ? 1'b0 : 1'b1);
        end

        // NMI held low: one request, cleared by ack, no retrigger.
        for (int i = 1; i <= 60; i++) begin
            nmi_pad_n = 1'b0;
            nmi_ack = (i == 40);
            step();
            chk("nmi_level", nmi_n, (i >= LAT_OUT && i < 40) ? 1'b0 : 1'b1);
        end
        nmi_ack = 1'b0;
        nmi_pad_n = 1'b1;
        repeat (10) step();
        // Ack on the same edge that detects a new falling edge.
        for (int i = 1; i <= 10; i++) begin
            nmi_pad_n = 1'b0;
            nmi_ack = (i == LAT_OUT);
            step();
            chk("nmi_set_wins", nmi_n, (i >= LAT_OUT) ? 1'b0 : 1'b1);
        end
        nmi_ack = 1'b1;
        step();
        nmi_ack = 1'b0;
        chk("nmi_ack_clear", nmi_n, 1'b1);
        nmi_pad_n = 1'b1;
        repeat (8) step();

        // SO falling and held low: a single one-cycle pulse.
        for (int i = 1; i <= 12; i++) begin
            so_pad_n = 1'b0;
            step();
            chk("so_pulse", so_n, (i == LAT_OUT) ? 1'b0 : 1'b1);
        end
        so_pad_n = 1'b1;
        repeat (8) step();

        // RDY single-cycle low: passes only with the filter compiled out.
        for (int i = 1; i <= 10; i++) begin
            rdy_pad = (i == 1) ? 1'b0 : 1'b1;
            step();
            chk("rdy_pulse1", rdy, (!FILT_ON && i == LAT_OUT) ? 1'b0 : 1'b1);
        end

        // Reset pad asserted in RUN; SO falling during HOLD gives no pulse.
        for (int i = 1; i <= 14; i++) begin
            res_pad_n = 1'b0;
            so_pad_n = (i >= 3 && i <= 8) ? 1'b0 : 1'b1;
            step();
            chk("res_assert", cpu_rst_n, (i < LAT_OUT) ? 1'b1 : 1'b0);
            chk("so_in_hold", so_n, 1'b1);
        end
        // Reset pad drops again three cycles into STRETCH, then a full stretch.
        for (int i = 1; i <= 9 + LAT_RST + 3; i++) begin
            res_pad_n = (i <= 3 || i >= 10) ? 1'b1 : 1'b0;
            step();
            chk("stretch_restart", cpu_rst_n, (i >= 9 + LAT_RST) ? 1'b1 : 1'b0);
        end

        // Random pads and acks against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) irq_pad_n = ~irq_pad_n;
            if ($urandom_range(0, 4) == 0) nmi_pad_n = ~nmi_pad_n;
            if ($urandom_range(0, 4) == 0) rdy_pad = ~rdy_pad;
            if ($urandom_range(0, 4) == 0) so_pad_n = ~so_pad_n;
            if (res_pad_n) begin
                if ($urandom_range(0, 199) == 0) res_pad_n = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                res_pad_n = 1'b1;
            end
            nmi_ack = ($urandom_range(0, 7) == 0);
            step();
        end
        nmi_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
